// File: rtl/dmg_lcd_cap_if.sv
// dmg_lcd_cap_if: LCD pin bundle in, captured pixel stream and status out
interface dmg_lcd_cap_if;
  logic       lcd_d0;
  logic       lcd_d1;
  logic       lcd_clk;
  logic       lcd_hsync;
  logic       lcd_vsync;
  logic       lcd_datal;
  logic       pix_we;
  logic [7:0] pix_x;
  logic [7:0] pix_y;
  logic [1:0] pix_data;
  logic       frame_start;
  logic       line_done;
  logic       sync_err;
  modport master (
    output lcd_d0, lcd_d1, lcd_clk, lcd_hsync, lcd_vsync, lcd_datal,
    input  pix_we, pix_x, pix_y, pix_data, frame_start, line_done, sync_err
  );
  modport slave (
    input  lcd_d0, lcd_d1, lcd_clk, lcd_hsync, lcd_vsync, lcd_datal,
    output pix_we, pix_x, pix_y, pix_data, frame_start, line_done, sync_err
  );
endinterface

// File: rtl/dmg_lcd_cap.sv
// dmg_lcd_cap: DMG LCD bus capture into pixel writes; stall watchdog enabled by DMG_LCD_CAP_WATCHDOG_EN
module dmg_lcd_cap #(
  parameter int HPIX     = 160,
  parameter int VPIX     = 144,
  parameter int WDOG_TOP = 4095
) (
  input logic          clk_8m,
  input logic          rst,
  dmg_lcd_cap_if.slave lcd
);
  typedef enum logic [1:0] {IDLE, WAIT_LINE, PIXELS, LINE_END} state_t;
  localparam int D0 = 0, D1 = 1, CK = 2, HS = 3, VS = 4, DL = 5;
  localparam logic [7:0] X_LAST = 8'(HPIX - 1);
  localparam logic [7:0] Y_LAST = 8'(VPIX - 1);
  logic [5:0] w_pins, r_s1, r_s2;
  logic       r_ck3, r_hs3, r_dl3;
  logic       r_clk_fall, r_hs_rise, r_hs_fall, r_hs_lvl, r_vs_lvl, r_dl_rise;
  logic [1:0] r_pd;
  logic       w_clk_ev;
  state_t     r_state;
`ifdef DMG_LCD_CAP_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_TOP + 1);
  logic [WW-1:0] r_wdog;
  logic          r_clk_edge;
  logic          w_wdog_clr;
  assign w_wdog_clr = r_clk_edge | r_hs_rise | r_hs_fall;
`endif
  assign w_pins   = {lcd.lcd_datal, lcd.lcd_vsync, lcd.lcd_hsync, lcd.lcd_clk, lcd.lcd_d1, lcd.lcd_d0};
  assign w_clk_ev = r_clk_fall & ~r_hs_lvl;

  // two-flop synchronizer, then registered edge pulses, levels and data all taken from stage two
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_ck3      <= 1'b0;
      r_hs3      <= 1'b0;
      r_dl3      <= 1'b0;
      r_clk_fall <= 1'b0;
      r_hs_rise  <= 1'b0;
      r_hs_fall  <= 1'b0;
      r_hs_lvl   <= 1'b0;
      r_vs_lvl   <= 1'b0;
      r_dl_rise  <= 1'b0;
      r_pd       <= '0;
`ifdef DMG_LCD_CAP_WATCHDOG_EN
      r_clk_edge <= 1'b0;
`endif
    end else begin
      r_s1       <= w_pins;
      r_s2       <= r_s1;
      r_ck3      <= r_s2[CK];
      r_hs3      <= r_s2[HS];
      r_dl3      <= r_s2[DL];
      r_clk_fall <= r_ck3 & ~r_s2[CK];
      r_hs_rise  <= ~r_hs3 & r_s2[HS];
      r_hs_fall  <= r_hs3 & ~r_s2[HS];
      r_hs_lvl   <= r_s2[HS];
      r_vs_lvl   <= r_s2[VS];
      r_dl_rise  <= ~r_dl3 & r_s2[DL];
      r_pd       <= ~r_s2[D1:D0];
`ifdef DMG_LCD_CAP_WATCHDOG_EN
      r_clk_edge <= r_ck3 ^ r_s2[CK];
`endif
    end
  end

  // line/frame sequencer; a new line (hsync rise) after a short or full line restarts at the next row
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      r_state         <= IDLE;
      lcd.pix_we      <= 1'b0;
      lcd.pix_x       <= '0;
      lcd.pix_y       <= '0;
      lcd.pix_data    <= '0;
      lcd.frame_start <= 1'b0;
      lcd.line_done   <= 1'b0;
      lcd.sync_err    <= 1'b0;
`ifdef DMG_LCD_CAP_WATCHDOG_EN
      r_wdog          <= '0;
`endif
    end else begin
      lcd.pix_we      <= 1'b0;
      lcd.frame_start <= 1'b0;
      lcd.line_done   <= r_dl_rise && r_state != IDLE;
      if (r_hs_rise && (r_state == PIXELS || r_state == LINE_END)) begin
        if (r_state == PIXELS) lcd.sync_err <= 1'b1;
        if (r_vs_lvl) begin
          lcd.pix_y       <= '0;
          lcd.frame_start <= 1'b1;
          r_state         <= WAIT_LINE;
        end else if (lcd.pix_y == Y_LAST) begin
          lcd.sync_err <= 1'b1;
          r_state      <= IDLE;
        end else begin
          lcd.pix_y <= lcd.pix_y + 8'd1;
          r_state   <= WAIT_LINE;
        end
      end else begin
        case (r_state)
          IDLE:
            if (r_hs_rise && r_vs_lvl) begin
              lcd.pix_y       <= '0;
              lcd.frame_start <= 1'b1;
              r_state         <= WAIT_LINE;
            end
          WAIT_LINE:
            if (r_hs_fall) begin
              lcd.pix_x <= '0;
              r_state   <= PIXELS;
            end else if (w_clk_ev) lcd.sync_err <= 1'b1;
          PIXELS:
            if (w_clk_ev) begin
              lcd.pix_we   <= 1'b1;
              lcd.pix_data <= r_pd;
              if (lcd.pix_x == X_LAST) r_state <= LINE_END;
            end else if (lcd.pix_we) lcd.pix_x <= lcd.pix_x + 8'd1;
          LINE_END:
            if (w_clk_ev) lcd.sync_err <= 1'b1;
        endcase
      end
`ifdef DMG_LCD_CAP_WATCHDOG_EN
      r_wdog <= (w_wdog_clr || r_state == IDLE) ? '0 : r_wdog + 1'b1;
      if (r_state != IDLE && r_wdog == WW'(WDOG_TOP)) begin
        lcd.sync_err <= 1'b1;
        r_state      <= IDLE;
        r_wdog       <= '0;
      end
`endif
    end
  end
endmodule
